// File: rtl/mpc_htu_if.sv
// Request, ISU, memory-controller, refill and credit signals of one mpc bank hit/tag unit.
// The master side drives requests and acks; the slave side is the hit/tag unit.
interface mpc_htu_if #(
    parameter int SET_W  = 3,
    parameter int WAY_W  = 2,
    parameter int WBUF_W = 7
);
    localparam int NLINE_W = WAY_W + SET_W;

    typedef struct packed {
        logic [2:0]        channel_1hot_id;
        logic [WBUF_W-1:0] wbuffer_id;
        logic [2:0]        op;
        logic [31:0]       addr;
        logic [255:0]      wdata;
    } bank_req_t;

    logic               u_bank_req_valid;
    logic               u_bank_req_ready;
    bank_req_t          u_bank_req;

    logic               d_isu_refill_valid;
    logic [SET_W-1:0]   d_isu_refill_set;
    logic [WAY_W-1:0]   d_isu_refill_way;

    logic               d_isu_valid;
    logic               d_isu_ready;
    logic [2:0]         d_isu_channel_1hot_id;
    logic [2:0]         d_isu_op;
    logic [NLINE_W-1:0] d_isu_id;
    logic [4:0]         d_isu_offset;
    logic [WBUF_W-1:0]  d_isu_wbuf_id;

    logic               d_memctl_valid;
    logic               d_memctl_ready;
    logic [2:0]         d_memctl_op;
    logic [NLINE_W-1:0] d_memctl_id;
    logic [31:0]        d_memctl_addr;

    logic               d_isu_crdt_valid;
    logic [NLINE_W-1:0] d_isu_crdt_way_set;

    modport slave (
        input  u_bank_req_valid, u_bank_req,
        input  d_isu_refill_valid, d_isu_refill_set, d_isu_refill_way,
        input  d_isu_ready, d_memctl_ready,
        input  d_isu_crdt_valid, d_isu_crdt_way_set,
        output u_bank_req_ready,
        output d_isu_valid, d_isu_channel_1hot_id, d_isu_op, d_isu_id, d_isu_offset, d_isu_wbuf_id,
        output d_memctl_valid, d_memctl_op, d_memctl_id, d_memctl_addr
    );

    modport master (
        output u_bank_req_valid, u_bank_req,
        output d_isu_refill_valid, d_isu_refill_set, d_isu_refill_way,
        output d_isu_ready, d_memctl_ready,
        output d_isu_crdt_valid, d_isu_crdt_way_set,
        input  u_bank_req_ready,
        input  d_isu_valid, d_isu_channel_1hot_id, d_isu_op, d_isu_id, d_isu_offset, d_isu_wbuf_id,
        input  d_memctl_valid, d_memctl_op, d_memctl_id, d_memctl_addr
    );
endinterface

// File: rtl/mpc_htu.sv
// Per-bank hit/tag unit of the multi-port cache: tag lookup, victim allocation,
// ISU command slot and a writeback/refill command sequencer toward the memory controller.
module mpc_htu #(
    parameter int SETS   = 8,
    parameter int WAYS   = 4,
    parameter int WBUF_W = 7
) (
    input  logic     clk,
    input  logic     rst_n,
    mpc_htu_if.slave bus
);
    localparam int SET_W   = $clog2(SETS);
    localparam int WAY_W   = $clog2(WAYS);
    localparam int OFF_W   = 5;
    localparam int BANK_W  = 2;
    localparam int TAG_W   = 32 - OFF_W - BANK_W - SET_W;
    localparam int NLINE_W = WAY_W + SET_W;

    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] MC_OP_REFILL = 3'd0;
    localparam logic [2:0] MC_OP_WB     = 3'd1;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_WB   = 2'd1,
        MC_RF   = 2'd2
    } mc_state_e;

    logic [TAG_W-1:0]   tag_r   [SETS][WAYS];
    logic [WAYS-1:0]    valid_r [SETS];
    logic [WAYS-1:0]    dirty_r [SETS];
    logic [WAYS-1:0]    busy_r  [SETS];
    logic [WAY_W-1:0]   rr_ptr_r;

    logic               isu_valid_r;
    logic [2:0]         isu_chan_r;
    logic [2:0]         isu_op_r;
    logic [NLINE_W-1:0] isu_id_r;
    logic [OFF_W-1:0]   isu_off_r;
    logic [WBUF_W-1:0]  isu_wbuf_r;

    mc_state_e          mc_state_r;
    mc_state_e          mc_state_nxt_s;
    logic [NLINE_W-1:0] mc_id_r;
    logic [31:0]        mc_wb_addr_r;
    logic [31:0]        mc_rf_addr_r;
    logic               mc_valid_s;
    logic [2:0]         mc_op_s;
    logic [31:0]        mc_addr_s;

    logic [SET_W-1:0]   req_set_s;
    logic [TAG_W-1:0]   req_tag_s;
    logic               req_wr_s;
    logic [WAYS-1:0]    set_valid_s;
    logic [WAYS-1:0]    set_busy_s;
    logic [WAYS-1:0]    match_vec_s;
    logic [WAYS-1:0]    free_vec_s;
    logic [WAY_W-1:0]   hit_way_s;
    logic [WAY_W-1:0]   inv_way_s;
    logic [WAY_W-1:0]   rr_cand_s;
    logic [WAY_W-1:0]   rr_way_s;
    logic [WAY_W-1:0]   victim_way_s;
    logic               hit_s;
    logic               match_busy_s;
    logic               inv_found_s;
    logic               any_free_s;
    logic               victim_evict_s;
    logic [31:0]        victim_addr_s;
    logic               ready_s;
    logic               accept_s;
    logic [SET_W-1:0]   crdt_set_s;
    logic [WAY_W-1:0]   crdt_way_s;
    logic               unused_wdata_s;

    assign req_set_s  = bus.u_bank_req.addr[OFF_W+BANK_W +: SET_W];
    assign req_tag_s  = bus.u_bank_req.addr[31 -: TAG_W];
    assign req_wr_s   = (bus.u_bank_req.op == OP_WRITE);
    assign crdt_set_s = bus.d_isu_crdt_way_set[SET_W-1:0];
    assign crdt_way_s = bus.d_isu_crdt_way_set[NLINE_W-1 -: WAY_W];
    assign unused_wdata_s = ^bus.u_bank_req.wdata;

    // Tag compare and victim candidates for the set addressed by the current request.
    always_comb begin
        set_valid_s = valid_r[req_set_s];
        set_busy_s  = busy_r[req_set_s];
        match_vec_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            match_vec_s[w] = (tag_r[req_set_s][w] == req_tag_s) && (set_valid_s[w] || set_busy_s[w]);
        end
        free_vec_s = ~set_valid_s & ~set_busy_s;
        hit_way_s  = '0;
        inv_way_s  = '0;
        rr_cand_s  = '0;
        rr_way_s   = rr_ptr_r;
        // Descending scan so the lowest index (or nearest to the pointer) wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way_s = match_vec_s[w] ? WAY_W'(w) : hit_way_s;
            inv_way_s = free_vec_s[w] ? WAY_W'(w) : inv_way_s;
            rr_cand_s = rr_ptr_r + WAY_W'(w);
            rr_way_s  = set_busy_s[rr_cand_s] ? rr_way_s : rr_cand_s;
        end
    end

    assign hit_s          = |match_vec_s;
    assign match_busy_s   = |(match_vec_s & set_busy_s);
    assign inv_found_s    = |free_vec_s;
    assign any_free_s     = |(~set_busy_s);
    assign victim_way_s   = inv_found_s ? inv_way_s : rr_way_s;
    assign victim_evict_s = set_valid_s[victim_way_s] & dirty_r[req_set_s][victim_way_s];
    assign victim_addr_s  = {tag_r[req_set_s][victim_way_s], bus.u_bank_req.addr[OFF_W +: BANK_W],
                             req_set_s, {OFF_W{1'b0}}};

    assign ready_s  = !isu_valid_r && (mc_state_r == MC_IDLE) && !match_busy_s && (hit_s || any_free_s);
    assign accept_s = bus.u_bank_req_valid && ready_s;
    assign bus.u_bank_req_ready = ready_s;

    // Line state array: refill/credit updates plus hit locking and miss allocation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
                busy_r[s]  <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_r[s][w] <= '0;
                end
            end
            rr_ptr_r <= '0;
        end else begin
            if (bus.d_isu_refill_valid) begin
                valid_r[bus.d_isu_refill_set][bus.d_isu_refill_way] <= 1'b1;
            end
            if (bus.d_isu_crdt_valid) begin
                busy_r[crdt_set_s][crdt_way_s] <= 1'b0;
            end
            if (accept_s && hit_s) begin
                busy_r[req_set_s][hit_way_s] <= 1'b1;
                if (req_wr_s) begin
                    dirty_r[req_set_s][hit_way_s] <= 1'b1;
                end
            end else if (accept_s) begin
                tag_r[req_set_s][victim_way_s]   <= req_tag_s;
                valid_r[req_set_s][victim_way_s] <= 1'b0;
                busy_r[req_set_s][victim_way_s]  <= 1'b1;
                dirty_r[req_set_s][victim_way_s] <= req_wr_s;
                rr_ptr_r <= rr_ptr_r + WAY_W'(1);
            end
        end
    end

    // ISU command slot: loaded on acceptance, held until the ISU takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isu_valid_r <= 1'b0;
            isu_chan_r  <= 3'd0;
            isu_op_r    <= 3'd0;
            isu_id_r    <= '0;
            isu_off_r   <= '0;
            isu_wbuf_r  <= '0;
        end else if (accept_s) begin
            isu_valid_r <= 1'b1;
            isu_chan_r  <= bus.u_bank_req.channel_1hot_id;
            isu_op_r    <= hit_s ? {2'b00, req_wr_s} : (victim_evict_s ? {2'b10, req_wr_s} : {2'b01, req_wr_s});
            isu_id_r    <= {(hit_s ? hit_way_s : victim_way_s), req_set_s};
            isu_off_r   <= bus.u_bank_req.addr[OFF_W-1:0];
            isu_wbuf_r  <= bus.u_bank_req.wbuffer_id;
        end else if (isu_valid_r && bus.d_isu_ready) begin
            isu_valid_r <= 1'b0;
        end
    end

    assign bus.d_isu_valid           = isu_valid_r;
    assign bus.d_isu_channel_1hot_id = isu_chan_r;
    assign bus.d_isu_op              = isu_op_r;
    assign bus.d_isu_id              = isu_id_r;
    assign bus.d_isu_offset          = isu_off_r;
    assign bus.d_isu_wbuf_id         = isu_wbuf_r;

    // Memctl payload captured at miss acceptance; the sequencer replays it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_id_r      <= '0;
            mc_wb_addr_r <= 32'd0;
            mc_rf_addr_r <= 32'd0;
        end else if (accept_s && !hit_s) begin
            mc_id_r      <= {victim_way_s, req_set_s};
            mc_wb_addr_r <= victim_addr_s;
            mc_rf_addr_r <= {bus.u_bank_req.addr[31:OFF_W], {OFF_W{1'b0}}};
        end
    end

    // Memctl sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_state_r <= MC_IDLE;
        end else begin
            mc_state_r <= mc_state_nxt_s;
        end
    end

    // Memctl sequencer next state: a dirty victim is written back before the refill.
    always_comb begin
        mc_state_nxt_s = mc_state_r;
        case (mc_state_r)
            MC_IDLE: begin
                if (accept_s && !hit_s) begin
                    mc_state_nxt_s = victim_evict_s ? MC_WB : MC_RF;
                end else begin
                    mc_state_nxt_s = MC_IDLE;
                end
            end
            MC_WB: begin
                if (bus.d_memctl_ready) begin
                    mc_state_nxt_s = MC_RF;
                end else begin
                    mc_state_nxt_s = MC_WB;
                end
            end
            MC_RF: begin
                if (bus.d_memctl_ready) begin
                    mc_state_nxt_s = MC_IDLE;
                end else begin
                    mc_state_nxt_s = MC_RF;
                end
            end
            default: mc_state_nxt_s = MC_IDLE;
        endcase
    end

    // Memctl sequencer outputs decoded from the state register.
    always_comb begin
        mc_valid_s = 1'b0;
        mc_op_s    = MC_OP_REFILL;
        mc_addr_s  = mc_rf_addr_r;
        case (mc_state_r)
            MC_WB: begin
                mc_valid_s = 1'b1;
                mc_op_s    = MC_OP_WB;
                mc_addr_s  = mc_wb_addr_r;
            end
            MC_RF: begin
                mc_valid_s = 1'b1;
                mc_op_s    = MC_OP_REFILL;
                mc_addr_s  = mc_rf_addr_r;
            end
            default: begin
                mc_valid_s = 1'b0;
                mc_op_s    = MC_OP_REFILL;
                mc_addr_s  = mc_rf_addr_r;
            end
        endcase
    end

    assign bus.d_memctl_valid = mc_valid_s;
    assign bus.d_memctl_op    = mc_op_s;
    assign bus.d_memctl_id    = mc_id_r;
    assign bus.d_memctl_addr  = mc_addr_s;
endmodule

// File: tb/tb_mpc_htu.sv
// Bench for mpc_htu: directed scenarios followed by random traffic, all checked
// against a line-level cache model with a queue of expected memory commands.
module tb_mpc_htu;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mpc_htu_if bus ();
    mpc_htu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: line table, round-robin pointer, ISU slot, memctl command queue.
    logic [21:0] m_tag   [8][4];
    bit          m_val   [8][4];
    bit          m_dirty [8][4];
    bit          m_busy  [8][4];
    int          m_rr;
    bit          e_isu_v;
    logic [31:0] e_isu_op, e_isu_id, e_isu_off, e_isu_chan, e_isu_wbuf;
    typedef struct {
        logic [31:0] op;
        logic [31:0] id;
        logic [31:0] addr;
    } mc_cmd_t;
    mc_cmd_t mcq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_tag[s][w] = 22'd0; m_val[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_busy[s][w] = 1'b0;
            end
        end
        m_rr = 0;
        e_isu_v = 1'b0;
        mcq.delete();
    endtask

    function automatic int m_find(input logic [31:0] a);
        int s = int'(a[9:7]);
        int r = -1;
        for (int k = 0; k < 4; k++) begin
            if (r < 0 && m_tag[s][k] == a[31:10] && (m_val[s][k] || m_busy[s][k])) r = k;
        end
        return r;
    endfunction

    function automatic bit m_ready(input logic [31:0] a);
        int s = int'(a[9:7]);
        int w = m_find(a);
        bit any = 1'b0;
        if (e_isu_v || mcq.size() != 0) return 1'b0;
        if (w >= 0) return !m_busy[s][w];
        for (int k = 0; k < 4; k++) begin
            if (!m_busy[s][k]) any = 1'b1;
        end
        return any;
    endfunction

    task automatic m_accept(input logic [31:0] a, input logic [2:0] op, input logic [2:0] chan,
                            input logic [6:0] wbuf);
        int  s = int'(a[9:7]);
        int  w = m_find(a);
        int  v = -1;
        bit  wr = (op == 3'd1);
        bit  ev;
        e_isu_v    = 1'b1;
        e_isu_chan = 32'(chan);
        e_isu_wbuf = 32'(wbuf);
        e_isu_off  = 32'(a[4:0]);
        if (w >= 0) begin
            e_isu_op = wr ? 32'd1 : 32'd0;
            e_isu_id = 32'(w * 8 + s);
            m_busy[s][w] = 1'b1;
            if (wr) m_dirty[s][w] = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (v < 0 && !m_val[s][k] && !m_busy[s][k]) v = k;
            end
            for (int k = 0; k < 4; k++) begin
                if (v < 0 && !m_busy[s][(m_rr + k) % 4]) v = (m_rr + k) % 4;
            end
            ev = m_val[s][v] && m_dirty[s][v];
            e_isu_id = 32'(v * 8 + s);
            if (ev) mcq.push_back('{op: 32'd1, id: e_isu_id, addr: {m_tag[s][v], a[6:5], a[9:7], 5'b0}});
            mcq.push_back('{op: 32'd0, id: e_isu_id, addr: {a[31:5], 5'b0}});
            e_isu_op = ev ? (wr ? 32'd5 : 32'd4) : (wr ? 32'd3 : 32'd2);
            m_tag[s][v] = a[31:10]; m_val[s][v] = 1'b0; m_busy[s][v] = 1'b1; m_dirty[s][v] = wr;
            m_rr = (m_rr + 1) % 4;
        end
    endtask

    // One clock: check ready, let the edge happen, advance the model, check outputs.
    task automatic tick();
        logic [31:0] a;
        bit rdy, acc, ir, mr, rf, cr;
        logic [2:0] op, ch, rs; logic [6:0] wb; logic [1:0] rw; logic [4:0] cws;
        #1;
        a  = bus.u_bank_req.addr; op = bus.u_bank_req.op;
        ch = bus.u_bank_req.channel_1hot_id; wb = bus.u_bank_req.wbuffer_id;
        ir = bus.d_isu_ready; mr = bus.d_memctl_ready;
        rf = bus.d_isu_refill_valid; rs = bus.d_isu_refill_set; rw = bus.d_isu_refill_way;
        cr = bus.d_isu_crdt_valid; cws = bus.d_isu_crdt_way_set;
        rdy = m_ready(a);
        chk("req_ready", 32'(bus.u_bank_req_ready), 32'(rdy));
        acc = bus.u_bank_req_valid && rdy;
        @(posedge clk);
        #1;
        if (e_isu_v && ir) e_isu_v = 1'b0;
        if (mcq.size() != 0 && mr) void'(mcq.pop_front());
        if (acc) m_accept(a, op, ch, wb);
        if (rf) m_val[int'(rs)][int'(rw)] = 1'b1;
        if (cr) m_busy[int'(cws[2:0])][int'(cws[4:3])] = 1'b0;
        bus.d_isu_refill_valid = 1'b0;
        bus.d_isu_crdt_valid   = 1'b0;
        chk("isu_valid", 32'(bus.d_isu_valid), 32'(e_isu_v));
        if (e_isu_v) begin
            chk("isu_op",   32'(bus.d_isu_op), e_isu_op);
            chk("isu_id",   32'(bus.d_isu_id), e_isu_id);
            chk("isu_off",  32'(bus.d_isu_offset), e_isu_off);
            chk("isu_chan", 32'(bus.d_isu_channel_1hot_id), e_isu_chan);
            chk("isu_wbuf", 32'(bus.d_isu_wbuf_id), e_isu_wbuf);
        end
        chk("mc_valid", 32'(bus.d_memctl_valid), 32'(mcq.size() != 0));
        if (mcq.size() != 0) begin
            chk("mc_op",   32'(bus.d_memctl_op), mcq[0].op);
            chk("mc_id",   32'(bus.d_memctl_id), mcq[0].id);
            chk("mc_addr", bus.d_memctl_addr, mcq[0].addr);
        end
    endtask

    task automatic set_req(input bit v, input logic [2:0] op, input logic [31:0] a);
        bus.u_bank_req_valid           = v;
        bus.u_bank_req.op              = op;
        bus.u_bank_req.addr            = a;
        bus.u_bank_req.channel_1hot_id = 3'(32'd1 << $urandom_range(0, 2));
        bus.u_bank_req.wbuffer_id      = 7'($urandom);
        bus.u_bank_req.wdata           = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic refill_credit(input int s, input int w);
        bus.d_isu_refill_valid = 1'b1; bus.d_isu_refill_set = 3'(s); bus.d_isu_refill_way = 2'(w);
        bus.d_isu_crdt_valid   = 1'b1; bus.d_isu_crdt_way_set = 5'(w * 8 + s);
        tick();
    endtask

    // Issue one request, drain both command slots, then refill and release its line.
    task automatic serve(input logic [2:0] op, input logic [31:0] a);
        int w;
        set_req(1'b1, op, a);
        bus.d_isu_ready = 1'b1; bus.d_memctl_ready = 1'b1;
        tick();
        bus.u_bank_req_valid = 1'b0;
        for (int i = 0; i < 10 && (e_isu_v || mcq.size() != 0); i++) tick();
        chk("drain_isu", 32'(bus.d_isu_valid), 32'd0);
        chk("drain_mc", 32'(bus.d_memctl_valid), 32'd0);
        w = m_find(a);
        if (w >= 0) refill_credit(int'(a[9:7]), w);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.d_isu_ready = 1'b0; bus.d_memctl_ready = 1'b0;
        bus.d_isu_refill_valid = 1'b0; bus.d_isu_refill_set = 3'd0; bus.d_isu_refill_way = 2'd0;
        bus.d_isu_crdt_valid = 1'b0; bus.d_isu_crdt_way_set = 5'd0;
        set_req(1'b0, 3'd0, 32'd0);
        do_reset();
        tick();

        // Read miss into an empty bank; ready stays low until both commands are taken.
        set_req(1'b1, 3'd0, 32'h0000_0010);
        tick();
        chk("tp1_isu_op", 32'(bus.d_isu_op), 32'd2);
        chk("tp1_isu_id", 32'(bus.d_isu_id), 32'd0);
        chk("tp1_isu_off", 32'(bus.d_isu_offset), 32'h10);
        chk("tp1_mc_op", 32'(bus.d_memctl_op), 32'd0);
        chk("tp1_mc_addr", bus.d_memctl_addr, 32'h0);
        bus.u_bank_req_valid = 1'b0;
        tick(); tick();
        bus.d_isu_ready = 1'b1; tick();
        bus.d_isu_ready = 1'b0; bus.d_memctl_ready = 1'b1; tick();
        bus.d_memctl_ready = 1'b0; tick();

        // Refill + credit, then read hit on the same line.
        refill_credit(0, 0);
        set_req(1'b1, 3'd0, 32'h0000_0008);
        tick();
        chk("tp2_isu_op", 32'(bus.d_isu_op), 32'd0);
        chk("tp2_isu_off", 32'(bus.d_isu_offset), 32'h8);
        chk("tp2_mc_valid", 32'(bus.d_memctl_valid), 32'd0);

        // Same line again while busy: held off until the credit lands.
        bus.d_isu_ready = 1'b1;
        tick(); tick(); tick();
        chk("tp3_busy_ready", 32'(bus.u_bank_req_ready), 32'd0);
        bus.d_isu_crdt_valid = 1'b1; bus.d_isu_crdt_way_set = 5'd0;
        tick();
        tick();
        bus.u_bank_req_valid = 1'b0;
        tick();
        bus.d_isu_crdt_valid = 1'b1; bus.d_isu_crdt_way_set = 5'd0;
        tick();

        // Fill set 0 with dirty lines, then a read miss evicts way 0.
        do_reset();
        for (int t = 0; t < 4; t++) serve(3'd1, 32'(t) << 10);
        bus.d_isu_ready = 1'b0; bus.d_memctl_ready = 1'b0;
        set_req(1'b1, 3'd0, 32'h0000_1000);
        tick();
        chk("tp4_isu_op", 32'(bus.d_isu_op), 32'd4);
        chk("tp4_isu_id", 32'(bus.d_isu_id), 32'd0);
        chk("tp4_wb_op", 32'(bus.d_memctl_op), 32'd1);
        chk("tp4_wb_addr", bus.d_memctl_addr, 32'h0);
        set_req(1'b1, 3'd0, 32'h0000_0080);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("tp5_hold_op", 32'(bus.d_isu_op), 32'd4);
        end
        bus.u_bank_req_valid = 1'b0;
        bus.d_memctl_ready = 1'b1; tick();
        bus.d_memctl_ready = 1'b0;
        chk("tp4_rf_op", 32'(bus.d_memctl_op), 32'd0);
        chk("tp4_rf_addr", bus.d_memctl_addr, 32'h0000_1000);

        // Reset with the refill still pending.
        rst_n = 1'b0;
        #1;
        chk("rst_isu_valid", 32'(bus.d_isu_valid), 32'd0);
        chk("rst_mc_valid", 32'(bus.d_memctl_valid), 32'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.d_isu_ready = 1'b0;
        set_req(1'b1, 3'd0, 32'h0000_1000);
        tick();
        chk("rst_lines_invalid", 32'(bus.d_isu_op), 32'd2);
        bus.u_bank_req_valid = 1'b0;
        bus.d_isu_ready = 1'b1; bus.d_memctl_ready = 1'b1;
        tick();
        refill_credit(0, 0);
        bus.d_isu_ready = 1'b0;
        set_req(1'b1, 3'd0, 32'h0000_0400);
        tick();
        chk("rst_way1_op", 32'(bus.d_isu_op), 32'd2);
        chk("rst_way1_id", 32'(bus.d_isu_id), 32'd8);
        bus.u_bank_req_valid = 1'b0;

        // Random traffic over two sets and six tags.
        for (int c = 0; c < 800; c++) begin
            int s, w;
            set_req(($urandom % 4) != 0, 3'($urandom % 2),
                    {22'($urandom_range(0, 5)), 2'b00, 3'($urandom_range(0, 1)), 5'($urandom)});
            bus.d_isu_ready    = ($urandom % 4) != 0;
            bus.d_memctl_ready = ($urandom % 4) != 0;
            s = int'($urandom_range(0, 1));
            w = int'($urandom_range(0, 3));
            if (m_busy[s][w] && ($urandom % 2) != 0) begin
                if (!m_val[s][w]) begin
                    bus.d_isu_refill_valid = 1'b1; bus.d_isu_refill_set = 3'(s); bus.d_isu_refill_way = 2'(w);
                end else begin
                    bus.d_isu_crdt_valid = 1'b1; bus.d_isu_crdt_way_set = 5'(w * 8 + s);
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mpc_htu.md
Name: mpc_htu

Overview:
- Per-bank hit/tag unit of the multi-port cache (mpc). Accepts one bank request per cycle and performs the tag lookup against its own tag/state array.
- Hits are forwarded to the issue unit (ISU). Misses allocate a victim line, notify the ISU, and issue writeback/refill commands to the memory controller.
- Per-line busy locks are released by ISU credits.

Parameters:
- SETS, 8, sets per bank; SET_W = log2(SETS) = 3.
- WAYS, 4, associativity; WAY_W = log2(WAYS) = 2.
- BANKS, 4, bank count; BANK_W = 2.
- CL_BYTES, 32, line size in bytes (clWidth 256 bits); OFF_W = 5.
- WBUF_W, 7, write-buffer index width (wbufSize 128).
- Derived: TAG_W = 32-OFF_W-BANK_W-SET_W = 22; NLINE_W = WAY_W+SET_W = 5.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- u_bank_req_valid  in  1  request valid.
- u_bank_req_ready  out  1  request accepted when valid&ready.
- u_bank_req  in  struct  fields: channel_1hot_id[2:0], wbuffer_id[WBUF_W], op[2:0] (0=READ, 1=WRITE), addr[31:0], wdata (ignored).
- d_isu_refill_valid  in  1  refill data written for set/way.
- d_isu_refill_set  in  SET_W  set of the refilled line.
- d_isu_refill_way  in  WAY_W  way of the refilled line.
- d_isu_valid  out  1  ISU command valid.
- d_isu_ready  in  1  ISU command ready.
- d_isu_channel_1hot_id  out  3  copied from request.
- d_isu_op  out  3  ISU command opcode.
- d_isu_id  out  NLINE_W  line id {way,set}.
- d_isu_offset  out  OFF_W  addr[4:0].
- d_isu_wbuf_id  out  WBUF_W  copied from request wbuffer_id.
- d_memctl_valid  out  1  memory controller command valid.
- d_memctl_ready  in  1  memory controller command ready.
- d_memctl_op  out  3  0=REFILL, 1=WRITEBACK.
- d_memctl_id  out  NLINE_W  {way,set} of the allocated line.
- d_memctl_addr  out  32  line-aligned address, low 5 bits zero.
- d_isu_crdt_valid  in  1  ISU credit: release line lock.
- d_isu_crdt_way_set  in  NLINE_W  {way,set} to unlock.

Interface decisions:
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Address split: offset = addr[4:0], bank = addr[6:5] (ignored), set = addr[9:7], tag = addr[31:10].
- Per-line state: tag, valid, dirty, busy. Reset clears all of it, the round-robin pointer, all output valids, and the FSM state.
- Lookup is combinational on the request. Match means tag equal and (valid or busy).
- u_bank_req_ready = 1 only when all of the following hold:
  - the ISU slot is empty;
  - the memctl FSM is IDLE;
  - the request does not match a busy line;
  - on a miss, at least one way of the set is non-busy.
- Ready is combinational; it does not depend on u_bank_req_valid.
- Hit, accepted at edge N:
  - From cycle N+1: d_isu_valid=1, op = 0 (RD_HIT) or 1 (WR_HIT), id = {hit way, set}.
  - A write hit sets dirty.
  - The line becomes busy.
- Miss victim selection:
  - First pick the lowest-index way with valid=0 and busy=0.
  - Otherwise pick the first non-busy way starting from a global 2-bit round-robin pointer. The pointer increments on every miss acceptance and wraps 3 -> 0.
- Miss line update, at edge N:
  - tag := new tag, valid := 0, busy := 1.
  - dirty := 1 for a write miss, 0 for a read miss.
- Miss ISU command, from cycle N+1:
  - Clean or invalid victim: op 2 (RD_MISS) or 3 (WR_MISS).
  - Valid and dirty victim: op 4 (RD_MISS_EVICT) or 5 (WR_MISS_EVICT).
- Miss memctl FSM: IDLE -> WB -> RF -> IDLE.
  - WB state (dirty victim only): op 1, addr = old victim line address.
  - RF state: op 0, addr = {addr[31:5], 5'b0}.
  - A clean victim goes directly IDLE -> RF.
  - Each state holds d_memctl_valid and its payload stable until d_memctl_ready, then advances.
- Output slot handshakes:
  - The ISU slot holds valid and payload stable until d_isu_ready.
  - ISU and memctl handshakes are independent of each other.
- d_isu_refill_valid sets valid for {set, way}.
- d_isu_crdt_valid clears busy for the given line.
- Simultaneous events:
  - Refill/credit updates and a new allocation to the same line in the same cycle cannot occur, because a busy line is never chosen as victim.
  - Refill/credit on a line and acceptance of a request to a different line in the same cycle both take effect.
  - A credit in cycle N is visible to the ready decision in cycle N+1.
- Reset mid-transaction drops all pending commands and line state.

Test Plan:
- Reset, then READ addr 0x0000_0010 -> next cycle d_isu_valid=1, op 2, id 0 ({way0,set0}), offset 0x10; d_memctl_valid=1, op 0, addr 0x0000_0000, id 0; u_bank_req_ready=0 until both are consumed.
- After the above, refill set0/way0 plus credit id 0, then READ 0x0000_0008 -> op 0 RD_HIT, id 0, offset 8, no memctl command.
- Request to a line whose busy is still set -> ready held 0 until the credit arrives; accepted the cycle after the credit.
- Fill all 4 ways of set 0 via WRITE misses (tags 0..3, refilled and credited), then READ a fifth tag -> op 5 is not expected (read miss); op 4 RD_MISS_EVICT, memctl WRITEBACK of the victim address followed by REFILL of the new address.
- d_isu_ready held low for 5 cycles -> d_isu_valid and payload stay stable and no new request is accepted.
- Assert rst_n low during a pending memctl RF -> all valids drop immediately and all lines are invalid afterwards.
